// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order requests to a variable-latency
// instruction memory, buffers returned words and presents one registered slot to decode.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pcD,
    output logic [31:0]     instrD,
    output logic            validD
);
    localparam logic [31:0]  NOP     = 32'h0000_0013;
    localparam int unsigned  FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned  TAG_AW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned  CNT_W   = $clog2(FIFO_DEPTH + MAX_OUTST + 1);

    localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] FIFO_LIM  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [XLEN-1:0]    pcQ;
    logic [XLEN-1:0]    tagMem [MAX_OUTST];
    logic [TAG_AW-1:0]  tagWr, tagRd;
    logic [XLEN-1:0]    fifoPc [FIFO_DEPTH];
    logic [31:0]        fifoInstr [FIFO_DEPTH];
    logic [FIFO_AW-1:0] fifoWr, fifoRd;
    logic [CNT_W-1:0]   fifoCnt, outst, discard;
    logic [CNT_W-1:0]   fifoCntNext, outstNext, discardNext;

    logic accept, respTake, respPush, fifoPop;

    function automatic logic [TAG_AW-1:0] tagInc(input logic [TAG_AW-1:0] p);
        return (p == TAG_AW'(MAX_OUTST - 1)) ? '0 : p + TAG_AW'(1);
    endfunction

    // Outstanding requests reserve FIFO space, so a response can always be pushed.
    assign imem_req  = !rst && !stallF && !flushD && (outst < OUTST_LIM) &&
                       ((outst + fifoCnt) < FIFO_LIM);
    assign imem_addr = pcQ;
    assign accept    = imem_req && imem_ready;
    assign respTake  = imem_rvalid && (outst != '0);
    assign respPush  = respTake && (discard == '0) && !flushD;
    assign fifoPop   = !flushD && !stallD && (fifoCnt != '0);

    always_comb begin
        outstNext   = outst;
        discardNext = discard;
        fifoCntNext = fifoCnt;
        if (accept && !respTake) begin
            outstNext = outst + ONE;
        end else if (!accept && respTake) begin
            outstNext = outst - ONE;
        end
        // On redirect every fetch still in flight is stale, including earlier discards.
        if (flushD) begin
            discardNext = outstNext;
        end else if (respTake && (discard != '0)) begin
            discardNext = discard - ONE;
        end
        if (flushD) begin
            fifoCntNext = '0;
        end else if (respPush && !fifoPop) begin
            fifoCntNext = fifoCnt + ONE;
        end else if (!respPush && fifoPop) begin
            fifoCntNext = fifoCnt - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcQ     <= RESET_PC;
            tagWr   <= '0;
            tagRd   <= '0;
            fifoWr  <= '0;
            fifoRd  <= '0;
            fifoCnt <= '0;
            outst   <= '0;
            discard <= '0;
            pcD     <= '0;
            instrD  <= NOP;
            validD  <= 1'b0;
        end else begin
            outst   <= outstNext;
            discard <= discardNext;
            fifoCnt <= fifoCntNext;
            if (flushD) begin
                pcQ <= br_target & ~XLEN'(3);
            end else if (accept) begin
                pcQ <= pcQ + XLEN'(4);
            end
            if (accept) begin
                tagWr <= tagInc(tagWr);
            end
            if (respTake) begin
                tagRd <= tagInc(tagRd);
            end
            if (flushD) begin
                fifoWr <= '0;
                fifoRd <= '0;
            end else begin
                if (respPush) begin
                    fifoWr <= fifoWr + FIFO_AW'(1);
                end
                if (fifoPop) begin
                    fifoRd <= fifoRd + FIFO_AW'(1);
                end
            end
            if (flushD) begin
                validD <= 1'b0;
                instrD <= NOP;
            end else if (!stallD) begin
                if (fifoCnt != '0) begin
                    pcD    <= fifoPc[fifoRd];
                    instrD <= fifoInstr[fifoRd];
                    validD <= 1'b1;
                end else begin
                    validD <= 1'b0;
                    instrD <= NOP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tagMem[tagWr] <= pcQ;
        end
        if (respPush) begin
            fifoPc[fifoWr]    <= tagMem[tagRd];
            fifoInstr[fifoWr] <= imem_rdata;
        end
    end

    outstBound:   assert property (@(posedge clk) disable iff (rst) outst <= OUTST_LIM);
    fifoBound:    assert property (@(posedge clk) disable iff (rst) fifoCnt <= FIFO_LIM);
    discardBound: assert property (@(posedge clk) disable iff (rst) discard <= outst);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable in-order memory model plus a
// linear sequence of steps with hand-computed expectations.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    logic [31:0] pendAddr[$];
    int          pendDue[$];
    logic [31:0] acceptLog[$];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pcD        (pcD),
        .instrD     (instrD),
        .validD     (validD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Memory: request accepted in cycle k answers in cycle k+lat, in order, one per cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pendAddr.delete();
            pendDue.delete();
            acceptLog.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req && imem_ready) begin
                pendAddr.push_back(imem_addr);
                pendDue.push_back((pendDue.size() > 0 && pendDue[$] >= cyc + lat) ?
                                  pendDue[$] + 1 : cyc + lat);
                acceptLog.push_back(imem_addr);
            end
            if (pendDue.size() > 0 && pendDue[0] <= cyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= memWord(pendAddr[0]);
                void'(pendAddr.pop_front());
                void'(pendDue.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic settle();
        #2;
        if (imem_rvalid === 1'b1) begin
            check($sformatf("rvalid_outst_c%0d", cyc), 32'(dut.outst != '0), 32'd1);
        end
    endtask

    task automatic checkSlot(input string tag, input logic [31:0] pc);
        check({tag, "_validD"}, 32'(validD), 32'd1);
        check({tag, "_pcD"}, pcD, pc);
        check({tag, "_instrD"}, instrD, memWord(pc));
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        br_target = '0; imem_ready = 1'b1; lat = 1;

        @(negedge clk);
        check("rst_validD", 32'(validD), 32'd0);
        check("rst_instrD", instrD, NOP);
        check("rst_pcD", pcD, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);

        // Streaming at L=1
        @(negedge clk); rst = 1'b0; cyc = 0; settle();
        check("t1_req_c0", 32'(imem_req), 32'd1);
        check("t1_addr_c0", imem_addr, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            nextCycle(); settle();
            if (c < 3) check($sformatf("t1_idle_c%0d", c), 32'(validD), 32'd0);
            else checkSlot($sformatf("t1_c%0d", c), 32'(4 * (c - 3)));
        end

        // Decode stall for five edges
        nextCycle(); stallD = 1'b1; settle();
        checkSlot("t2_c9", 32'd24);
        nextCycle(); settle();
        check("t2_req_c10", 32'(imem_req), 32'd1);
        checkSlot("t2_c10", 32'd24);
        nextCycle(); settle();
        check("t2_req_c11", 32'(imem_req), 32'd0);
        check("t2_addr_c11", imem_addr, 32'd44);
        nextCycle(); settle();
        nextCycle(); settle();
        check("t2_req_c13", 32'(imem_req), 32'd0);
        checkSlot("t2_c13", 32'd24);
        nextCycle(); stallD = 1'b0; settle();
        checkSlot("t2_c14", 32'd24);
        nextCycle(); settle();
        check("t2_req_c15", 32'(imem_req), 32'd1);
        check("t2_addr_c15", imem_addr, 32'd44);
        checkSlot("t2_c15", 32'd28);
        for (int c = 16; c <= 19; c++) begin
            nextCycle(); settle();
            checkSlot($sformatf("t2_c%0d", c), 32'(4 * (c - 8)));
        end

        // L=3, two in flight at 0x10/0x14, then redirect to 0x100
        @(negedge clk); rst = 1'b1; lat = 3;
        @(negedge clk); rst = 1'b0; cyc = 0; flushD = 1'b1; br_target = 32'h10; settle();
        check("t3_req_c0", 32'(imem_req), 32'd0);
        nextCycle(); flushD = 1'b0; settle();
        check("t3_req_c1", 32'(imem_req), 32'd1);
        check("t3_addr_c1", imem_addr, 32'h10);
        nextCycle(); settle();
        check("t3_addr_c2", imem_addr, 32'h14);
        nextCycle(); flushD = 1'b1; br_target = 32'h103; settle();
        check("t3_req_c3", 32'(imem_req), 32'd0);
        nextCycle(); flushD = 1'b0; settle();
        check("t3_req_c4", 32'(imem_req), 32'd0);
        check("t3_addr_c4", imem_addr, 32'h100);
        check("t3_rvalid_c4", 32'(imem_rvalid), 32'd1);
        nextCycle(); settle();
        check("t3_req_c5", 32'(imem_req), 32'd1);
        check("t3_rvalid_c5", 32'(imem_rvalid), 32'd1);
        check("t3_valid_c5", 32'(validD), 32'd0);
        for (int c = 6; c <= 9; c++) begin
            nextCycle(); settle();
            check($sformatf("t3_valid_c%0d", c), 32'(validD), 32'd0);
        end
        nextCycle(); settle();
        checkSlot("t3_c10", 32'h100);
        nextCycle(); settle();
        checkSlot("t3_c11", 32'h104);

        // Memory not ready for four cycles while stallF toggles
        @(negedge clk); rst = 1'b1; lat = 1; imem_ready = 1'b0;
        @(negedge clk); rst = 1'b0; cyc = 0; settle();
        check("t4_req_c0", 32'(imem_req), 32'd1);
        check("t4_addr_c0", imem_addr, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            nextCycle(); stallF = (c % 2 == 1); settle();
            check($sformatf("t4_req_c%0d", c), 32'(imem_req), 32'((c % 2) == 0));
            check($sformatf("t4_addr_c%0d", c), imem_addr, 32'd0);
        end
        nextCycle(); stallF = 1'b0; imem_ready = 1'b1; settle();
        check("t4_req_c4", 32'(imem_req), 32'd1);
        check("t4_addr_c4", imem_addr, 32'd0);
        check("t4_nacc_c4", 32'(acceptLog.size()), 32'd0);
        nextCycle(); settle();
        check("t4_addr_c5", imem_addr, 32'd4);
        nextCycle(); settle();
        check("t4_nacc_c6", 32'(acceptLog.size()), 32'd2);
        check("t4_acc0", acceptLog[0], 32'd0);
        check("t4_acc1", acceptLog[1], 32'd4);
        nextCycle(); settle();
        checkSlot("t4_c7", 32'd0);
        nextCycle(); settle();
        checkSlot("t4_c8", 32'd4);

        // flushD with stallD and a returning word in the same cycle
        nextCycle(); flushD = 1'b1; stallD = 1'b1; br_target = 32'h200; settle();
        check("t5_rvalid_c9", 32'(imem_rvalid), 32'd1);
        check("t5_req_c9", 32'(imem_req), 32'd0);
        checkSlot("t5_c9", 32'd8);
        nextCycle(); flushD = 1'b0; stallD = 1'b0; settle();
        check("t5_valid_c10", 32'(validD), 32'd0);
        check("t5_instr_c10", instrD, NOP);
        check("t5_addr_c10", imem_addr, 32'h200);
        nextCycle(); settle();
        check("t5_valid_c11", 32'(validD), 32'd0);
        nextCycle(); settle();
        check("t5_valid_c12", 32'(validD), 32'd0);
        nextCycle(); lat = 3; settle();
        checkSlot("t5_c13", 32'h200);

        // Asynchronous reset with two requests in flight
        nextCycle(); settle();
        nextCycle(); settle();
        check("t6_outst_c15", 32'(dut.outst), 32'd2);
        check("t6_req_c15", 32'(imem_req), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_validD", 32'(validD), 32'd0);
        check("t6_rst_instrD", instrD, NOP);
        check("t6_rst_pcD", pcD, 32'd0);
        check("t6_rst_req", 32'(imem_req), 32'd0);
        @(negedge clk); rst = 1'b0; cyc = 0; lat = 1; settle();
        check("t6_addr_c0", imem_addr, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            nextCycle(); settle();
            if (c < 3) check($sformatf("t6_idle_c%0d", c), 32'(validD), 32'd0);
            else checkSlot($sformatf("t6_c%0d", c), 32'(4 * (c - 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
